icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 40 ++++
 rtl/icache_array.sv | 32 +++
 rtl/icache.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
// Address split: [17:16] region, [17:8] tag, [7:2] line index, [1:0] byte offset.
// The line record holds {tag, instruction word}; valid bits live in the top level.
package icache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INSTR_WIDTH = 32;

    // 64 lines of one word each
    localparam int LINES  = 64;
    localparam int IDX_W  = 6;
    localparam int IDX_LO = 2;
    localparam int IDX_HI = 7;

    // 10-bit tag taken from a[17:8]; bits above 17 do not take part in lookup
    localparam int TAG_W  = 10;
    localparam int TAG_LO = 8;
    localparam int TAG_HI = 17;

    // a[17:16] selects the region; 2'b11 is uncached I/O space
    localparam int REGION_LO = 16;
    localparam int REGION_HI = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]       tag;
        logic [INSTR_WIDTH-1:0] dat;
    } line_t;

    // I/O-space addresses are never allocated and never hit
    function automatic logic is_io(input logic [1:0] region);
        return region == 2'b11;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag+data storage for the icache: 64 x 42 bits, one read and one write port.
// Read data is registered: index presented with rd_en appears on rd_line after the edge.
// No flow control of its own; the caller gates rd_en/wr_en with its global ready.
module icache_array
    import icache_pkg::*;
(
    input  logic             clk,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output line_t            rd_line,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  line_t            wr_line
);

    line_t mem [LINES];

    // Fill port: one line written per completed miss
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
    end

    // Registered read; holds its value while rd_en is low so a frozen lookup keeps its data
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_line <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped 64-line instruction cache between iFetch and memCtrl.
// Hit: if_instr_en two cycles after acceptance; miss: one cycle after mc_instr_en.
// rdy_in low freezes everything; roll_back abandons the in-flight request.
module icache
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   roll_back,
    input  logic                   if_a_en,
    input  logic [ADDR_WIDTH-1:0]  if_a,
    output logic                   if_instr_en,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   mc_a_en,
    output logic [ADDR_WIDTH-1:0]  mc_a,
    input  logic                   mc_instr_en,
    input  logic [INSTR_WIDTH-1:0] mc_instr
);

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_WIDTH-1:0]  req_a;
    logic [LINES-1:0]       valid;
    line_t                  rd_line;
    line_t                  wr_line;

    logic                   hit;
    logic                   req_io;
    logic [IDX_W-1:0]       req_idx;
    logic [TAG_W-1:0]       req_tag;

    // decoded per-cycle actions
    logic                   accept;
    logic                   rsp_hit;
    logic                   rsp_fill;
    logic                   miss_start;
    logic                   mc_drop;
    logic                   fill_we;

    assign req_idx = req_a[IDX_HI:IDX_LO];
    assign req_tag = req_a[TAG_HI:TAG_LO];
    assign req_io  = is_io(req_a[REGION_HI:REGION_LO]);

    // The array read was launched on the accepting edge, so rd_line belongs to req_a in LOOKUP
    assign hit = valid[req_idx] && (rd_line.tag == req_tag) && !req_io;

    assign wr_line.tag = req_tag;
    assign wr_line.dat = mc_instr;

    icache_array u_array (
        .clk     (clk),
        .rd_en   (rdy_in && accept),
        .rd_idx  (if_a[IDX_HI:IDX_LO]),
        .rd_line (rd_line),
        .wr_en   (rdy_in && fill_we),
        .wr_idx  (req_idx),
        .wr_line (wr_line)
    );

    // State register; global ready stalls the FSM in place
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else if (rdy_in) begin
            state <= state_nxt;
        end
    end

    // Next-state: roll_back always returns to IDLE from an active request
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (roll_back || hit) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_MISS;
                end
            end
            ST_MISS: begin
                if (roll_back || mc_instr_en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Action decode; a line returned together with roll_back is still written (the data is
    // correct) but never reported to iFetch. No acceptance while the previous response is on
    // the bus so if_instr_en cannot pulse on consecutive cycles.
    always_comb begin
        accept     = 1'b0;
        rsp_hit    = 1'b0;
        rsp_fill   = 1'b0;
        miss_start = 1'b0;
        mc_drop    = 1'b0;
        fill_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = if_a_en && !roll_back && !if_instr_en;
            end
            ST_LOOKUP: begin
                if (!roll_back) begin
                    rsp_hit    = hit;
                    miss_start = !hit;
                end
            end
            ST_MISS: begin
                fill_we  = mc_instr_en && !req_io;
                rsp_fill = mc_instr_en && !roll_back;
                mc_drop  = mc_instr_en || roll_back;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

    // Request latch, response and memCtrl handshake registers
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            req_a       <= '0;
            if_instr_en <= 1'b0;
            if_instr    <= '0;
            mc_a_en     <= 1'b0;
            mc_a        <= '0;
        end else if (rdy_in) begin
            if_instr_en <= rsp_hit || rsp_fill;
            if (accept) begin
                req_a <= if_a;
            end
            if (rsp_hit) begin
                if_instr <= rd_line.dat;
            end else if (rsp_fill) begin
                if_instr <= mc_instr;
            end
            if (miss_start) begin
                mc_a    <= req_a;
                mc_a_en <= 1'b1;
            end else if (mc_drop) begin
                mc_a_en <= 1'b0;
            end
        end
    end

    // Valid bits kept in flops so reset clears every line at once; flushes never clear them
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (rdy_in && fill_we) begin
            valid[req_idx] <= 1'b1;
        end
    end

endmodule
